// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared opcodes, state encoding and control bundle for the sequencer
package seq_pkg;

  localparam logic [3:0] OP_RR   = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;

  typedef struct packed {
    logic [7:0]  alu_op;
    logic [4:0]  mux_a;
    logic [4:0]  mux_b;
    logic [15:0] regs_en;
    logic [15:0] imm;
    logic        imm_control;
    logic        buff_en;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction word to datapath control bundle
module instr_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_t       ctrl,
  output logic        is_jump,
  output logic        is_halt,
  output logic [7:0]  imm8
);

  logic [3:0] op;
  logic [3:0] rd;

  assign op   = ir[OP_MSB:OP_LSB];
  assign rd   = ir[RD_MSB:RD_LSB];
  assign imm8 = ir[IMM_MSB:0];

  always_comb begin
    ctrl    = '0;
    is_jump = (op == OP_JUMP);
    is_halt = (op == OP_HALT);
    if (op == OP_RR) begin
      ctrl.alu_op  = {4'h0, ir[EXT_MSB:EXT_LSB]};
      ctrl.mux_a   = {1'b0, rd};
      ctrl.mux_b   = {1'b0, ir[RS_MSB:RS_LSB]};
      ctrl.regs_en = 16'h0001 << rd;
      ctrl.buff_en = 1'b1;
    end else if (!is_jump && !is_halt) begin
      ctrl.alu_op      = {4'h0, op};
      ctrl.mux_a       = {1'b0, rd};
      ctrl.imm         = {{8{imm8[7]}}, imm8};
      ctrl.imm_control = 1'b1;
      ctrl.regs_en     = 16'h0001 << rd;
      ctrl.buff_en     = 1'b1;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - fetch/decode/exec sequencer driving the register-file/ALU datapath
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        alu_op,
  output logic [4:0]        muxA,
  output logic [4:0]        muxB,
  output logic [15:0]       regs_en,
  output logic [15:0]       imm,
  output logic              imm_control,
  output logic              buff_en,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  ctrl_t             dec_ctrl, ctrl_g;
  logic              is_jump, is_halt;
  logic [7:0]        jump_imm;

  instr_decode u_decode (
    .ir      (ir_q),
    .ctrl    (dec_ctrl),
    .is_jump (is_jump),
    .is_halt (is_halt),
    .imm8    (jump_imm)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = START_ADDR;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
        ir_d    = mem_rdata;
      end
      ST_EXEC: begin
        // HALT leaves pc on the HALT word so the debug port shows where it stopped
        if (is_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
          pc_d    = is_jump ? ADDR_W'(jump_imm) : pc_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Gating on the registered state makes every control drop asynchronously with reset
  assign ctrl_g      = (state_q == ST_EXEC) ? dec_ctrl : '0;
  assign alu_op      = ctrl_g.alu_op;
  assign muxA        = ctrl_g.mux_a;
  assign muxB        = ctrl_g.mux_b;
  assign regs_en     = ctrl_g.regs_en;
  assign imm         = ctrl_g.imm;
  assign imm_control = ctrl_g.imm_control;
  assign buff_en     = ctrl_g.buff_en;

  assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign halted   = (state_q == ST_HALTED);
  assign mem_addr = pc_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - randomized self-checking bench against an instruction-level model
module tb_datapath_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, which;
  logic [15:0] mem16 [256];
  logic [15:0] mem4  [16];
  logic [15:0] rdata16, rdata4;

  logic [15:0] d16_addr, d16_pc, d16_regs, d16_imm;
  logic [7:0]  d16_alu;
  logic [4:0]  d16_ma, d16_mb;
  logic        d16_ic, d16_be, d16_busy, d16_halt;
  logic [3:0]  d4_addr, d4_pc;
  logic [15:0] d4_regs, d4_imm;
  logic [7:0]  d4_alu;
  logic [4:0]  d4_ma, d4_mb;
  logic        d4_ic, d4_be, d4_busy, d4_halt;

  datapath_sequencer #(.ADDR_W(16), .START_ADDR(16'h0000)) dut16 (
    .clk(clk), .reset(rst_n), .start(start && !which),
    .mem_addr(d16_addr), .mem_rdata(rdata16),
    .alu_op(d16_alu), .muxA(d16_ma), .muxB(d16_mb), .regs_en(d16_regs), .imm(d16_imm),
    .imm_control(d16_ic), .buff_en(d16_be), .busy(d16_busy), .halted(d16_halt), .pc(d16_pc)
  );

  datapath_sequencer #(.ADDR_W(4), .START_ADDR(4'hC)) dut4 (
    .clk(clk), .reset(rst_n), .start(start && which),
    .mem_addr(d4_addr), .mem_rdata(rdata4),
    .alu_op(d4_alu), .muxA(d4_ma), .muxB(d4_mb), .regs_en(d4_regs), .imm(d4_imm),
    .imm_control(d4_ic), .buff_en(d4_be), .busy(d4_busy), .halted(d4_halt), .pc(d4_pc)
  );

  always @(posedge clk) begin
    rdata16 <= mem16[d16_addr[7:0]];
    rdata4  <= mem4[d4_addr];
  end

  logic [15:0] o_addr, o_pc;
  logic [51:0] o_bundle;
  logic        o_busy, o_halt;
  assign o_addr   = which ? {12'h0, d4_addr} : d16_addr;
  assign o_pc     = which ? {12'h0, d4_pc} : d16_pc;
  assign o_busy   = which ? d4_busy : d16_busy;
  assign o_halt   = which ? d4_halt : d16_halt;
  assign o_bundle = which ? {d4_alu, d4_ma, d4_mb, d4_regs, d4_imm, d4_ic, d4_be}
                          : {d16_alu, d16_ma, d16_mb, d16_regs, d16_imm, d16_ic, d16_be};

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected EXEC-cycle controls straight from the instruction-set rules
  function automatic logic [51:0] model_ctrl(input logic [15:0] ins);
    int op, rd, v;
    logic [7:0]  a;
    logic [4:0]  ma, mb;
    logic [15:0] re, im;
    logic        ic, be;
    op = int'(ins[15:12]);
    rd = int'(ins[11:8]);
    a = 0; ma = 0; mb = 0; re = 0; im = 0; ic = 0; be = 0;
    if (op <= 13) begin
      re = 16'(1 << rd);
      be = 1'b1;
      ma = 5'(rd);
      if (op == 0) begin
        a  = 8'(ins[7:4]);
        mb = 5'(ins[3:0]);
      end else begin
        a  = 8'(op);
        v  = int'(ins[7:0]);
        if (v > 127) v = v - 256;
        im = 16'(v);
        ic = 1'b1;
      end
    end
    return {a, ma, mb, re, im, ic, be};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int max_instr, input bit poke, output bit got_halt);
    logic [15:0] pc, mask, ins;
    mask = which ? 16'h000F : 16'hFFFF;
    pc   = which ? 16'h000C : 16'h0000;
    got_halt = 1'b0;
    @(negedge clk);
    check("pre_busy", o_busy, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < max_instr; n++) begin
      ins = which ? mem4[pc[3:0]] : mem16[pc[7:0]];
      check("fetch_st", {o_busy, o_halt}, 2'b10);
      check("fetch_addr", o_addr, pc);
      check("fetch_pc", o_pc, pc);
      check("fetch_ctrl", o_bundle, 52'h0);
      @(posedge clk); #1;
      check("decode_st", {o_busy, o_halt}, 2'b10);
      check("decode_addr", o_addr, pc);
      check("decode_ctrl", o_bundle, 52'h0);
      if (poke && $urandom_range(0, 1) == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("exec_st", {o_busy, o_halt}, 2'b10);
      check("exec_addr", o_addr, pc);
      check("exec_ctrl", o_bundle, model_ctrl(ins));
      @(posedge clk); #1;
      if (ins[15:12] == 4'hF) begin
        check("halt_st", {o_busy, o_halt}, 2'b01);
        check("halt_pc", o_pc, pc);
        check("halt_ctrl", o_bundle, 52'h0);
        got_halt = 1'b1;
        return;
      end
      pc = (ins[15:12] == 4'hE) ? (16'(ins[7:0]) & mask) : ((pc + 16'd1) & mask);
    end
  endtask

  bit hit;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    which = 1'b0;
    foreach (mem16[i]) mem16[i] = 16'h0000;
    foreach (mem4[i])  mem4[i]  = 16'h0000;
    #1;
    check("rst_st", {o_busy, o_halt}, 2'b00);
    check("rst_pc", o_pc, 16'h0000);
    check("rst_ctrl", o_bundle, 52'h0);
    @(negedge clk);
    rst_n = 1'b1;

    mem16[0]     = 16'h5101;
    mem16[1]     = 16'h0251;
    mem16[2]     = 16'h53FF;
    mem16[3]     = 16'hE010;
    mem16[8'h10] = 16'hF000;
    run(10, 1'b1, hit);
    check("dir_halt", hit, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("halt_hold", {o_busy, o_halt}, 2'b01);
    run(10, 1'b0, hit);
    check("restart_halt", hit, 1'b1);

    // Reset in the middle of the ADDI EXEC cycle
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_regs", o_bundle[33:18], 16'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", o_bundle, 52'h0);
    check("midrst_st", {o_busy, o_halt}, 2'b00);
    check("midrst_pc", o_pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < 8; it++) begin
      foreach (mem16[i]) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 2)       mem16[i] = 16'hF000;
        else if (r == 2) mem16[i] = {8'hE0, 8'($urandom_range(0, 255))};
        else             mem16[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
      end
      run(40, 1'b1, hit);
      if (!hit) do_reset();
    end

    which = 1'b1;
    foreach (mem4[i]) mem4[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
    run(20, 1'b1, hit);
    do_reset();
    mem4[2] = 16'hF000;
    run(10, 1'b1, hit);
    check("wrap_halt", hit, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
